// File: rtl/inst_cache_responder.sv
// Direct-mapped instruction cache, 4-word lines, refilled one word at a time from backing memory.
// Optional hit/miss counters are enabled by defining INST_CACHE_STATS_EN.
module inst_cache_responder #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instruction_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 28 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic [27:0]             base_q, base_d;
  logic [Lines-1:0]        valid_q, valid_d;
  logic [TagBits-1:0]      tag_q  [Lines];
  logic [31:0]             data_q [Lines][4];

  logic                    data_we;
  logic                    tag_we;
  logic                    lookup_hit;
  logic [1:0]              pc_word;
  logic [INDEX_BITS-1:0]   pc_index;
  logic [TagBits-1:0]      pc_tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [TagBits-1:0]      fill_tag;
  logic                    unused_pc_bits;

  assign pc_word        = pc_i[3:2];
  assign pc_index       = pc_i[INDEX_BITS+3:4];
  assign pc_tag         = pc_i[31:INDEX_BITS+4];
  assign fill_index     = base_q[INDEX_BITS-1:0];
  assign fill_tag       = base_q[27:INDEX_BITS];
  assign unused_pc_bits = ^pc_i[1:0];

  assign lookup_hit = (state_q == StIdle) && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    base_d        = base_q;
    valid_d       = valid_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    stall_o       = 1'b1;
    instruction_o = 32'h0000_0000;
    mem_req_o     = 1'b0;
    mem_addr_o    = 32'h0000_0000;

    if (rst_i) begin
      // Outputs are forced quiet for the whole reset cycle, even mid-fill.
      stall_o = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lookup_hit) begin
            stall_o       = 1'b0;
            instruction_o = data_q[pc_index][pc_word];
          end else begin
            // Invalidate the victim now so partial data can never be reported as a hit.
            base_d            = pc_i[31:4];
            valid_d[pc_index] = 1'b0;
            k_d               = 2'd0;
            state_d           = StFill;
          end
        end
        StFill: begin
          mem_req_o  = 1'b1;
          mem_addr_o = {base_q, k_q, 2'b00};
          if (mem_ready_i) begin
            data_we = 1'b1;
            k_d     = k_q + 2'd1;
            if (k_q == 2'd3) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          tag_we              = 1'b1;
          valid_d[fill_index] = 1'b1;
          state_d             = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      base_q  <= 28'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      valid_q <= valid_d;
    end
  end

  // Data and tag storage carry no reset; validity alone gates their use.
  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_q[fill_index][k_q] <= mem_rdata_i;
    end
    if (tag_we) begin
      tag_q[fill_index] <= fill_tag;
    end
  end

`ifdef INST_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else if (state_q == StIdle) begin
      if (lookup_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: doc/inst_cache_responder.md
INST_CACHE_RESPONDER -- requirements
Module: inst_cache_responder

Interface
REQ-001 Parameter INDEX_BITS, default 4, gives 2^INDEX_BITS direct-mapped lines of 4 words (16 bytes) each.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 pc  input  32  fetch address from the core; bits [1:0] ignored.
REQ-005 instruction  output  32  instruction word for pc; combinational on hit.
REQ-006 stall  output  1  high while instruction is not valid for the current pc; drives the core's cache-stall input.
REQ-007 mem_req  output  1  backing-memory read request.
REQ-008 mem_addr  output  32  word-aligned backing-memory read address.
REQ-009 mem_ready  input  1  backing memory: mem_rdata valid this cycle.
REQ-010 mem_rdata  input  32  backing-memory read data.

Function
REQ-011 Address split: word = pc[3:2], index = pc[INDEX_BITS+3:4], tag = pc[31:INDEX_BITS+4].
REQ-012 Hit = state IDLE, line[index] valid, and stored tag == tag; on hit instruction = data[index][word] and stall = 0 in the same cycle.
REQ-013 On a non-hit, instruction = 0x00000000 (nop) and stall = 1.
REQ-014 FSM states: IDLE, FILL, DONE.
REQ-015 IDLE: on miss, latch the line base address {pc[31:4],4'b0} and go to FILL at the next edge; otherwise stay.
REQ-016 FILL: mem_req = 1, mem_addr = base + 4*k for word counter k (0..3); mem_addr and mem_req stay stable until mem_ready is sampled high.
REQ-017 FILL: when mem_ready is high, store mem_rdata into word k of the target line and increment k; the next word is requested the following cycle; after k = 3 is captured, go to DONE.
REQ-018 DONE: mem_req = 0; write tag and set valid for the filled line; return to IDLE at the next edge.
REQ-019 mem_req is 0 in IDLE and DONE; stall = 1 in FILL and DONE, whatever pc is.
REQ-020 Latency with mem_ready held high: a miss detected in cycle 0 gives stall high in cycles 0-5 and a hit in cycle 6. Each wait cycle on mem_ready adds one cycle.
REQ-021 A pc change during FILL/DONE does not alter the fill in progress. On return to IDLE, the current pc is looked up again and may start a new fill.
REQ-022 The line being filled holds valid = 0 from FILL entry until the DONE write; a partially filled line is never reported as a hit.
REQ-023 Valid, tag and data are written only as defined in REQ-017 and REQ-018.

Reset
REQ-024 While rst is high: state = IDLE, k = 0, all valid bits cleared, mem_req = 0, mem_addr = 0, stall = 0, instruction = 0. Data and tag arrays are not cleared.
REQ-025 A reset during FILL aborts the fill: mem_req = 0 at the next edge and any mem_ready after that is ignored.
REQ-026 The first cycle after reset with any pc is a miss.

Configuration
REQ-027 With macro INST_CACHE_STATS_EN defined:
- adds outputs hit_count[31:0] and miss_count[31:0], both cleared by rst;
- hit_count increments on each IDLE-state hit cycle;
- miss_count increments on each IDLE-to-FILL transition;
- both counters wrap modulo 2^32.
REQ-028 Without INST_CACHE_STATS_EN the counter ports and logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset, then pc = 0x00000000 with mem_ready = 1 and mem_rdata = addr+0x100 -> mem_addr sequence 0x0, 0x4, 0x8, 0xC; stall high for 6 cycles; then instruction = 0x00000100.
REQ-030 After REQ-029, pc = 0x4, 0x8, 0xC on consecutive cycles -> stall = 0 and instruction = 0x104, 0x108, 0x10C with no mem_req.
REQ-031 pc = 0x00000100 (same index as 0x0, different tag) -> refill; then pc = 0x0 -> miss again (eviction).
REQ-032 mem_ready low for 3 cycles on word 2 -> mem_addr held at base+0x8, mem_req held high, stall high for 9 cycles in total.
REQ-033 Assert rst during FILL at k = 2, then release with the same pc -> mem_req = 0 after the reset edge, and a fresh fill starts at word 0.
REQ-034 With INST_CACHE_STATS_EN, the REQ-029 + REQ-030 sequence -> miss_count = 1, hit_count = 4.
